// File: rtl/queue_arbiter.sv
// queue_arbiter: four requesters, round-robin arbitrated into a one-entry output register that feeds an instruction queue.
// Build option QARB_BURST_EN: the winner keeps the grant for up to BURST_MAX consecutive words.
module queue_arbiter #(
  parameter int unsigned BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req_valid,
  input  logic [63:0] req_data,
  output logic [3:0]  grant,
  output logic        q_inEnable,
  input  logic        q_inReady,
  output logic [15:0] q_dataIn,
  output logic        busy
);

  if (BURST_MAX < 1 || BURST_MAX > 15) begin : g_bad_burst_max
    $error("queue_arbiter: BURST_MAX must be in 1..15");
  end

  logic        r_out_valid;
  logic [15:0] r_out_data;
  logic [1:0]  r_rr_ptr;
  logic        w_slot_open;
  logic        w_any;
  logic        w_do_grant;
  logic [1:0]  w_search_ptr;
  logic [1:0]  w_win_idx;
  logic [1:0]  w_grant_idx;

  // The register can be refilled in the same cycle the queue drains it.
  assign w_slot_open = !r_out_valid || q_inReady;

  always_comb begin
    w_any     = 1'b0;
    w_win_idx = w_search_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req_valid[w_search_ptr + 2'(k)]) begin
        w_any     = 1'b1;
        w_win_idx = w_search_ptr + 2'(k);
      end
    end
  end

`ifdef QARB_BURST_EN
  // state   | meaning
  // ST_ARB  | no owner; round-robin from r_rr_ptr
  // ST_LOCK | r_owner holds the grant while valid and under BURST_MAX words
  typedef enum logic {ST_ARB, ST_LOCK} state_t;

  state_t      r_state;
  logic [1:0]  r_owner;
  logic [3:0]  r_burst_cnt;
  logic        w_lock_cont;

  assign w_lock_cont  = (r_state == ST_LOCK) && req_valid[r_owner] &&
                        (r_burst_cnt < 4'(BURST_MAX));
  assign w_search_ptr = (r_state == ST_LOCK) ? r_owner + 2'd1 : r_rr_ptr;
  assign w_grant_idx  = w_lock_cont ? r_owner : w_win_idx;
  assign w_do_grant   = rst_n && w_slot_open && (w_lock_cont || w_any);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ARB;
      r_owner     <= 2'd0;
      r_burst_cnt <= 4'd0;
      r_rr_ptr    <= 2'd0;
    end else begin
      case (r_state)
        ST_ARB: begin
          if (w_do_grant) begin
            r_state     <= ST_LOCK;
            r_owner     <= w_grant_idx;
            r_burst_cnt <= 4'd1;
          end
        end
        ST_LOCK: begin
          if (w_slot_open) begin
            if (w_lock_cont) begin
              r_burst_cnt <= r_burst_cnt + 4'd1;
            end else begin
              // Lock ends; a different winner may start its own burst right away.
              r_rr_ptr <= r_owner + 2'd1;
              if (w_any) begin
                r_owner     <= w_win_idx;
                r_burst_cnt <= 4'd1;
              end else begin
                r_state     <= ST_ARB;
                r_burst_cnt <= 4'd0;
              end
            end
          end
        end
        default: r_state <= ST_ARB;
      endcase
    end
  end
`else
  assign w_search_ptr = r_rr_ptr;
  assign w_grant_idx  = w_win_idx;
  assign w_do_grant   = rst_n && w_slot_open && w_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= 2'd0;
    end else if (w_do_grant) begin
      r_rr_ptr <= w_grant_idx + 2'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= 16'd0;
    end else if (w_do_grant) begin
      r_out_valid <= 1'b1;
      r_out_data  <= req_data[{w_grant_idx, 4'b0000} +: 16];
    end else if (r_out_valid && q_inReady) begin
      r_out_valid <= 1'b0;
    end
  end

  assign grant      = w_do_grant ? (4'b0001 << w_grant_idx) : 4'b0000;
  assign q_inEnable = r_out_valid;
  assign q_dataIn   = r_out_data;
  assign busy       = r_out_valid;

endmodule

// File: doc/queue_arbiter.md
QUEUE_ARBITER -- requirements
Module: queue_arbiter

Interface
REQ-001 Parameter: BURST_MAX, default 4, max consecutive grants to one requester when QARB_BURST_EN is defined (legal 1..15).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 Port: req_valid  input  4  per-requester word-valid; bit i = requester i.
REQ-005 Port: req_data  input  64  requester words; bits [16i+15:16i] = requester i.
REQ-006 Port: grant  output  4  one-hot; bit i high = requester i's word accepted this cycle.
REQ-007 Port: q_inEnable  output  1  write strobe to the instruction queue.
REQ-008 Port: q_inReady  input  1  queue can accept a word this cycle.
REQ-009 Port: q_dataIn  output  16  word presented to the queue.
REQ-010 Port: busy  output  1  output register holds an undelivered word.

Function
REQ-011 One-entry output register (out_valid, out_data); q_inEnable = out_valid, q_dataIn = out_data, busy = out_valid.
REQ-012 Transfer to queue occurs when q_inEnable && q_inReady at a rising edge.
REQ-013 Accept slot open when !out_valid || q_inReady (drain and refill in the same cycle allowed).
REQ-014 grant is combinational: zero when no slot is open or req_valid == 0, else exactly one bit, the winner.
REQ-015 Round-robin: 2-bit pointer rr_ptr; search order rr_ptr, rr_ptr+1, ... mod 4; first valid requester wins.
REQ-016 On grant to requester i: out_data <= req_data[i], out_valid <= 1, rr_ptr <= (i+1) mod 4 (wrap 3->0).
REQ-017 Slot open with no grant: out_valid <= 0 if the queue took the word, else unchanged.
REQ-018 Latency: word granted in cycle N appears on q_dataIn/q_inEnable in cycle N+1.
REQ-019 out_data stable while out_valid && !q_inReady (queue full backpressure); grant stays 0.
REQ-020 Requester may drop or change req_valid/req_data at any time; only granted cycles transfer.
REQ-021 No word lost or duplicated; words from one requester reach the queue in grant order.
REQ-022 Fairness: continuously-valid requester granted within 4 open slots (round-robin mode).

Reset
REQ-023 On rst_n low, asynchronously: out_valid=0, out_data=0, rr_ptr=0, burst_cnt=0, owner=0; hence q_inEnable=0, busy=0, grant=0.
REQ-024 Reset mid-transfer discards the held word; first grant after release is from the lowest valid index at or above 0.

Configuration
REQ-025 Macro QARB_BURST_EN defined: 2-state FSM ARB / LOCK with owner register and 4-bit burst_cnt.
REQ-026 With QARB_BURST_EN: ARB grant to i -> LOCK, owner=i, burst_cnt=1, rr_ptr unchanged until lock ends.
REQ-027 With QARB_BURST_EN in LOCK: owner granted on each open slot while req_valid[owner]; burst_cnt increments per grant.
REQ-028 With QARB_BURST_EN: LOCK -> ARB when req_valid[owner]=0 at an open slot or burst_cnt reaches BURST_MAX; rr_ptr <= owner+1 mod 4; same-cycle arbitration among others proceeds normally.
REQ-029 Without QARB_BURST_EN: no FSM/owner/burst_cnt logic; pure per-word round-robin of REQ-015/016.

Verification
REQ-030 req_valid=4'b1111, q_inReady=1 continuous, rr_ptr=0 -> grant 0001,0010,0100,1000,0001; words reach q_dataIn one cycle later in that order.
REQ-031 Single requester 2 valid, data 16'hA5A5, q_inReady=1 -> grant=0100 every cycle, q_dataIn=A5A5 with q_inEnable from cycle 2.
REQ-032 Word 16'h1234 held, q_inReady=0 for 5 cycles, req_valid=4'b0011 -> grant=0, q_dataIn=1234 stable; q_inReady=1 -> 1234 transferred and new grant same cycle.
REQ-033 rst_n pulsed low while busy=1 -> q_inEnable=0, busy=0 immediately (asynchronous), no transfer; after release first grant per REQ-024.
REQ-034 QARB_BURST_EN, BURST_MAX=4, req_valid=4'b0011 continuous -> grants 0001 x4, 0010 x4, 0001 x4.
REQ-035 Scoreboard under random req_valid/q_inReady, 10000 cycles, both macro settings -> every granted word delivered exactly once, per-requester order preserved.
